imem_fetch_arb: RTL and testbench
=================================

IMEM_FETCH_ARB -- requirements
Module: imem_fetch_arb

Interface
REQ-001 Parameter AW, 10, instruction-memory word-address width (1024 words).
REQ-002 Parameter STARVE_MAX, 4, max consecutive loader grants while a fetch is pending.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 fetch_req  in  1  core requests an instruction.
REQ-006 fetch_addr  in  32  byte address (PC).
REQ-007 fetch_ready  out  1  request accepted this cycle.
REQ-008 fetch_valid  out  1  response available.
REQ-009 fetch_instr  out  32  fetched instruction.
REQ-010 fetch_err  out  1  response is an error (misaligned or out of range).
REQ-011 fetch_resp_ready  in  1  core consumes the response.
REQ-012 ld_req  in  1  program loader write request.
REQ-013 ld_addr  in  AW  loader word address.
REQ-014 ld_data  in  32  loader write data.
REQ-015 ld_ack  out  1  loader write performed this cycle.
REQ-016 mem_addr  out  AW  memory word address.
REQ-017 mem_rd_en  out  1  memory read strobe.
REQ-018 mem_wr_en  out  1  memory write strobe.
REQ-019 mem_wdata  out  32  memory write data.
REQ-020 mem_rdata  in  32  memory read data, valid the cycle after mem_rd_en.

Function
REQ-021 The FSM SHALL have states IDLE, RD_WAIT and RESP.
REQ-022 fetch_ready, ld_ack, mem_rd_en and mem_wr_en SHALL be combinational decodes of IDLE state, requests and starve_cnt; mem_addr/mem_wdata driven only while a strobe is high, else 0.
REQ-023 In IDLE the loader SHALL win if ld_req and (!fetch_req or starve_cnt < STARVE_MAX); that cycle: mem_wr_en=1, mem_addr=ld_addr, mem_wdata=ld_data, ld_ack=1, remain IDLE.
REQ-024 starve_cnt SHALL increment (saturating at STARVE_MAX) on each loader grant with fetch_req high, and clear on any fetch acceptance or any IDLE cycle without fetch_req.
REQ-025 Otherwise if fetch_req, fetch SHALL be accepted: fetch_ready=1; if fetch_addr[1:0]!=0 or fetch_addr[31:AW+2]!=0, no memory strobe, err_q<=1, next RESP; else mem_rd_en=1, mem_addr=fetch_addr[AW+1:2], next RD_WAIT.
REQ-026 RD_WAIT SHALL capture mem_rdata into instr_q, clear err_q, go to RESP (one cycle, unconditional).
REQ-027 RESP SHALL drive fetch_valid=1, fetch_instr=instr_q (0 when error), fetch_err=err_q, held stable until fetch_resp_ready=1, then IDLE.
REQ-028 Latency: accept in cycle N -> fetch_valid in N+2 (N+1 for errors); back-to-back fetches with fetch_resp_ready=1 every 3 cycles.
REQ-029 No strobes and no ld_ack SHALL occur in RD_WAIT or RESP; ld_req waits (holding ld_addr/ld_data) until ack.
REQ-030 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, starve_cnt=0, instr_q=0, err_q=0; all outputs 0.
REQ-032 Reset during RD_WAIT/RESP SHALL discard the in-flight fetch; no fetch_valid follows reset.

Structure
REQ-033 Shared package imem_pkg SHALL hold the state enum, IMEM_AW=10 and STARVE_MAX default.
REQ-034 Single module, no sub-modules; memory array is external.

Verification
REQ-035 fetch_req, fetch_addr=0x10, mem word 4=0x000002B7 -> mem_rd_en/mem_addr=4 at N, fetch_valid with 0x000002B7 at N+2.
REQ-036 fetch_addr=0x6 -> no mem strobe, fetch_valid+fetch_err at N+1, fetch_instr=0.
REQ-037 ld_req and fetch_req held continuously -> 4 ld_acks, then 1 fetch accept, pattern repeats.
REQ-038 ld_req ld_addr=3 ld_data=0xDEADBEEF then fetch 0xC -> fetch_instr=0xDEADBEEF.
REQ-039 fetch_resp_ready low 5 cycles in RESP -> fetch_instr stable, ld_req not acked until handshake.
REQ-040 rst_n low in RD_WAIT -> outputs 0 immediately, IDLE after release, no stale fetch_valid.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch arbiter.
//   fetch_state_e  : arbiter FSM state encoding
//   IMEM_AW        : instruction-memory word-address width (1024 words)
//   STARVE_MAX_DEF : default limit on back-to-back loader grants while a fetch waits
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } fetch_state_e;

   localparam int IMEM_AW        = 10;
   localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/imem_fetch_arb_if.sv
// Bus bundle for the fetch arbiter: core fetch channel, loader write channel
// and the external single-port memory.
//   master : core / loader / memory side (drives requests and mem_rdata)
//   slave  : arbiter side (drives handshakes, responses and memory strobes)
interface imem_fetch_arb_if #(
   parameter int AW = imem_pkg::IMEM_AW
);
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [31:0]   fetch_instr;
   logic          fetch_err;
   logic          fetch_resp_ready;

   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic          ld_ack;

   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic          mem_wr_en;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport master (
      output fetch_req, fetch_addr, fetch_resp_ready,
      output ld_req, ld_addr, ld_data,
      output mem_rdata,
      input  fetch_ready, fetch_valid, fetch_instr, fetch_err,
      input  ld_ack,
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );

   modport slave (
      input  fetch_req, fetch_addr, fetch_resp_ready,
      input  ld_req, ld_addr, ld_data,
      input  mem_rdata,
      output fetch_ready, fetch_valid, fetch_instr, fetch_err,
      output ld_ack,
      output mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );
endinterface

// File: rtl/imem_fetch_arb.sv
// Arbitrates a single-port instruction memory between core fetches and a
// program loader. The loader wins while no fetch is pending, or for at most
// STARVE_MAX consecutive grants while one is; then the fetch goes through.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : imem_fetch_arb_if.slave (fetch, loader and memory channels)
//
// state   | meaning
// IDLE    | arbitrate loader write vs. fetch accept
// RD_WAIT | memory read in flight, capture mem_rdata
// RESP    | response presented until core takes it
module imem_fetch_arb
   import imem_pkg::*;
#(
   parameter int AW         = IMEM_AW,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   imem_fetch_arb_if.slave   bus
);

   localparam int SCW = $clog2(STARVE_MAX + 1);
   localparam logic [SCW-1:0] SMAX = SCW'(STARVE_MAX);

   fetch_state_e   state_q, state_d;
   logic [SCW-1:0] starve_cnt, starve_d;
   logic [31:0]    instr_q, instr_d;
   logic           err_q, err_d;

   logic           ld_win;
   logic           addr_bad;
   logic           fetch_ready_c, fetch_valid_c, fetch_err_c, ld_ack_c;
   logic           rd_en_c, wr_en_c;
   logic [AW-1:0]  mem_addr_c;
   logic [31:0]    mem_wdata_c, fetch_instr_c;

   assign addr_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                     (bus.fetch_addr[31:AW+2] != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         starve_cnt <= '0;
         instr_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_cnt <= starve_d;
         instr_q    <= instr_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_cnt;
      instr_d       = instr_q;
      err_d         = err_q;
      ld_win        = 1'b0;
      fetch_ready_c = 1'b0;
      fetch_valid_c = 1'b0;
      fetch_err_c   = 1'b0;
      fetch_instr_c = '0;
      ld_ack_c      = 1'b0;
      rd_en_c       = 1'b0;
      wr_en_c       = 1'b0;
      mem_addr_c    = '0;
      mem_wdata_c   = '0;
      unique case (state_q)
         IDLE: begin
            ld_win = bus.ld_req && (!bus.fetch_req || (starve_cnt < SMAX));
            if (ld_win) begin
               wr_en_c     = 1'b1;
               ld_ack_c    = 1'b1;
               mem_addr_c  = bus.ld_addr;
               mem_wdata_c = bus.ld_data;
               if (bus.fetch_req)
                  starve_d = (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1;
               else
                  starve_d = '0;
            end else begin
               starve_d = '0;
               if (bus.fetch_req) begin
                  fetch_ready_c = 1'b1;
                  if (addr_bad) begin
                     err_d   = 1'b1;
                     state_d = RESP;
                  end else begin
                     rd_en_c    = 1'b1;
                     mem_addr_c = bus.fetch_addr[AW+1:2];
                     state_d    = RD_WAIT;
                  end
               end
            end
         end
         RD_WAIT: begin
            instr_d = bus.mem_rdata;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            fetch_valid_c = 1'b1;
            fetch_err_c   = err_q;
            fetch_instr_c = err_q ? 32'h0 : instr_q;
            if (bus.fetch_resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low for the whole reset pulse, not just after the
   // state register clears, so an asserted ld_req cannot be acked in reset.
   assign bus.fetch_ready = rst_n & fetch_ready_c;
   assign bus.fetch_valid = rst_n & fetch_valid_c;
   assign bus.fetch_err   = rst_n & fetch_err_c;
   assign bus.fetch_instr = rst_n ? fetch_instr_c : 32'h0;
   assign bus.ld_ack      = rst_n & ld_ack_c;
   assign bus.mem_rd_en   = rst_n & rd_en_c;
   assign bus.mem_wr_en   = rst_n & wr_en_c;
   assign bus.mem_addr    = rst_n ? mem_addr_c : '0;
   assign bus.mem_wdata   = rst_n ? mem_wdata_c : 32'h0;

endmodule

// File: tb/tb_imem_fetch_arb.sv
// Directed bench for imem_fetch_arb with a behavioural memory and a queue of
// expected fetch responses.
module tb_imem_fetch_arb;
   import imem_pkg::*;

   localparam int AW = IMEM_AW;

   logic clk;
   logic rst_n;
   int   vectors;
   int   errs;

   logic [31:0] ref_mem [1024];
   logic [31:0] mem     [1024];
   logic [32:0] exp_q [$];

   imem_fetch_arb_if #(.AW(AW)) bus ();

   imem_fetch_arb #(.AW(AW), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_data = d;
      #1;
      n = 0;
      while (!bus.ld_ack && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("ld_ack_timeout", 32'(n < 20), 32'd1);
      chk("ld_wr_en", 32'(bus.mem_wr_en), 32'd1);
      chk("ld_mem_addr", 32'(bus.mem_addr), 32'(a));
      chk("ld_wdata", bus.mem_wdata, d);
      ref_mem[a] = d;
      @(negedge clk);
      bus.ld_req = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] a, input int hold, input bit ld_during);
      int n, lat;
      logic bad;
      logic [32:0] e;
      bad = (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
      bus.fetch_resp_ready = 1'b0;
      @(negedge clk);
      bus.fetch_req = 1'b1; bus.fetch_addr = a;
      #1;
      n = 0;
      while (!bus.fetch_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("accept_timeout", 32'(n < 20), 32'd1);
      exp_q.push_back(bad ? {1'b1, 32'h0} : {1'b0, ref_mem[a[AW+1:2]]});
      if (bad) begin
         chk("err_no_strobe", 32'(bus.mem_rd_en | bus.mem_wr_en), 32'd0);
      end else begin
         chk("rd_en", 32'(bus.mem_rd_en), 32'd1);
         chk("rd_addr", 32'(bus.mem_addr), 32'(a[AW+1:2]));
      end
      lat = 0;
      do begin
         @(negedge clk);
         bus.fetch_req = 1'b0;
         #1; lat++;
         if (!bus.fetch_valid)
            chk("wait_no_strobe", 32'(bus.mem_rd_en | bus.mem_wr_en), 32'd0);
      end while (!bus.fetch_valid && lat < 10);
      chk("latency", lat, bad ? 32'd1 : 32'd2);
      e = exp_q.pop_front();
      if (ld_during) begin
         bus.ld_req = 1'b1; bus.ld_addr = 10'd50; bus.ld_data = 32'hA5A5_0F0F;
         #1;
         chk("resp_ld_blocked", 32'(bus.ld_ack), 32'd0);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         chk("hold_valid", 32'(bus.fetch_valid), 32'd1);
         chk("hold_instr", bus.fetch_instr, e[31:0]);
         chk("hold_ld_ack", 32'(bus.ld_ack), 32'd0);
      end
      chk("resp_instr", bus.fetch_instr, e[31:0]);
      chk("resp_err", 32'(bus.fetch_err), 32'(e[32]));
      bus.fetch_resp_ready = 1'b1;
      @(negedge clk);
      bus.fetch_resp_ready = 1'b0;
      #1;
      chk("valid_drop", 32'(bus.fetch_valid), 32'd0);
      if (ld_during) begin
         chk("ld_after_resp", 32'(bus.ld_ack), 32'd1);
         chk("ld_after_addr", 32'(bus.mem_addr), 32'd50);
         ref_mem[50] = 32'hA5A5_0F0F;
         @(negedge clk);
         bus.ld_req = 1'b0;
      end
   endtask

   initial begin
      int ph;
      int n;
      vectors = 0; errs = 0;
      rst_n = 1'b0;
      bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.fetch_resp_ready = 1'b0;
      bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      #12;
      chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rst_ready", 32'(bus.fetch_ready), 32'd0);
      chk("rst_strobes", 32'(bus.mem_rd_en | bus.mem_wr_en), 32'd0);
      chk("rst_instr", bus.fetch_instr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      do_load(10'd4, 32'h0000_02B7);
      do_load(10'd3, 32'hDEAD_BEEF);
      do_load(10'd7, 32'h1234_5678);

      do_fetch(32'h10, 0, 1'b0);
      do_fetch(32'hC, 0, 1'b0);
      do_fetch(32'h6, 0, 1'b0);
      do_fetch(32'h1000, 0, 1'b0);
      do_fetch(32'h1C, 5, 1'b1);
      do_fetch(32'hC8, 0, 1'b0);

      // loader and fetch both held: 4 acks, accept, read, response, repeat
      @(negedge clk);
      bus.ld_req = 1'b1; bus.ld_addr = 10'd100; bus.ld_data = 32'h0000_0055;
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h10; bus.fetch_resp_ready = 1'b1;
      ref_mem[100] = 32'h0000_0055;
      for (int i = 0; i < 14; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         ph = i % 7;
         chk("starve_ld_ack", 32'(bus.ld_ack), 32'(ph < 4));
         chk("starve_fready", 32'(bus.fetch_ready), 32'(ph == 4));
         chk("starve_valid", 32'(bus.fetch_valid), 32'(ph == 6));
         chk("starve_excl", 32'(bus.mem_rd_en & bus.mem_wr_en), 32'd0);
         if (ph == 6) chk("starve_instr", bus.fetch_instr, ref_mem[4]);
      end
      @(negedge clk);
      bus.ld_req = 1'b0; bus.fetch_req = 1'b0; bus.fetch_resp_ready = 1'b0;

      // reset while the read is in flight
      @(negedge clk);
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h10;
      #1;
      chk("rstfl_accept", 32'(bus.fetch_ready), 32'd1);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      bus.ld_req = 1'b1; bus.ld_addr = 10'd9; bus.ld_data = 32'h0000_0099;
      rst_n = 1'b0;
      #1;
      chk("rstfl_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rstfl_ld_ack", 32'(bus.ld_ack), 32'd0);
      chk("rstfl_strobes", 32'(bus.mem_rd_en | bus.mem_wr_en), 32'd0);
      @(negedge clk);
      bus.ld_req = 1'b0;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (bus.fetch_valid) n++;
      end
      chk("rstfl_no_stale", n, 32'd0);
      do_fetch(32'h10, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
